// File: rtl/wishbone_ram_slave.sv
// Wishbone classic-cycle slave backed by word-addressed on-chip RAM.
// Parameterised wait states, byte selects, registered single-cycle ack.
module wishbone_ram_slave #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wishbone_addr_i,
  input  logic [31:0] wishbone_data_i,
  input  logic        wishbone_we_i,
  input  logic [3:0]  wishbone_sel_i,
  input  logic        wishbone_stb_i,
  input  logic        wishbone_cyc_i,
  output logic [31:0] wishbone_data_o,
  output logic        wishbone_ack_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic        ack_q, ack_d;
  logic [31:0] data_q, data_d;

  logic [31:0] mem [2**ADDR_WIDTH];

  logic                  req;
  logic                  commit;
  logic [31:0]           src_addr;
  logic [31:0]           src_data;
  logic                  src_we;
  logic [3:0]            src_sel;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  wr_en;
  logic                  unused_addr_bits;

  assign req = wishbone_cyc_i & wishbone_stb_i;

  // With zero wait states the commit edge is the sampling edge, so the
  // access must use the live bus values rather than the (not yet) latched ones.
  always_comb begin
    if (state_q == ST_IDLE) begin
      src_addr = wishbone_addr_i;
      src_data = wishbone_data_i;
      src_we   = wishbone_we_i;
      src_sel  = wishbone_sel_i;
    end else begin
      src_addr = addr_q;
      src_data = wdata_q;
      src_we   = we_q;
      src_sel  = sel_q;
    end
    in_range = (src_addr >> (ADDR_WIDTH + 2)) == '0;
    idx      = src_addr[ADDR_WIDTH+1:2];
  end

  assign unused_addr_bits = ^{wishbone_addr_i[1:0], addr_q[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    sel_d   = sel_q;
    commit  = 1'b0;
    ack_d   = 1'b0;
    data_d  = '0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = wishbone_addr_i;
          wdata_d = wishbone_data_i;
          we_d    = wishbone_we_i;
          sel_d   = wishbone_sel_i;
          cnt_d   = 4'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            state_d = ST_ACK;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = ST_ACK;
            commit  = 1'b1;
          end
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (commit) begin
      ack_d = 1'b1;
      if (!src_we && in_range) begin
        data_d = mem[idx];
      end
    end
  end

  // Gated by reset so an access pending while reset is asserted never lands.
  assign wr_en = commit & src_we & in_range & rst;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (src_sel[i]) begin
          mem[idx][8*i +: 8] <= src_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      ack_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
    end
  end

  assign wishbone_ack_o  = ack_q;
  assign wishbone_data_o = data_q;

endmodule

// File: tb/tb_wishbone_ram_slave.sv
// Directed bench for wishbone_ram_slave: one instance with zero wait states,
// one with three; expected read data queued at issue and popped at ack.
module tb_wishbone_ram_slave;

  logic        clk;
  logic        rst;
  logic        cyc   [2];
  logic        stb   [2];
  logic        we    [2];
  logic [31:0] adr   [2];
  logic [31:0] dat_i [2];
  logic [3:0]  sel   [2];
  logic [31:0] dat_o [2];
  logic        ack   [2];

  int unsigned ws [2];

  typedef struct {
    int          d;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  int n_checks;
  int n_pass;

  wishbone_ram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
    .clk             (clk),
    .rst             (rst),
    .wishbone_addr_i (adr[0]),
    .wishbone_data_i (dat_i[0]),
    .wishbone_we_i   (we[0]),
    .wishbone_sel_i  (sel[0]),
    .wishbone_stb_i  (stb[0]),
    .wishbone_cyc_i  (cyc[0]),
    .wishbone_data_o (dat_o[0]),
    .wishbone_ack_o  (ack[0])
  );

  wishbone_ram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(3)) dut1 (
    .clk             (clk),
    .rst             (rst),
    .wishbone_addr_i (adr[1]),
    .wishbone_data_i (dat_i[1]),
    .wishbone_we_i   (we[1]),
    .wishbone_sel_i  (sel[1]),
    .wishbone_stb_i  (stb[1]),
    .wishbone_cyc_i  (cyc[1]),
    .wishbone_data_o (dat_o[1]),
    .wishbone_ack_o  (ack[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  // Issue one transfer; checks ack/data every cycle up to one past the ack.
  task automatic xfer(input int d, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] s,
                      input logic [31:0] exp_rd, input string tag);
    exp_t e;
    e.d    = d;
    e.data = w ? 32'h0 : exp_rd;
    sb.push_back(e);
    @(posedge clk); #1;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w;
    adr[d] = a; dat_i[d] = wd; sel[d] = s;
    for (int c = 0; c <= int'(ws[d]) + 2; c++) begin
      @(negedge clk);
      if (c == int'(ws[d]) + 1) begin
        check({tag, "_ack"}, {31'b0, ack[d]}, 32'd1);
        if (sb.size() == 0) begin
          check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check({tag, "_data"}, dat_o[e.d], e.data);
        end
      end else begin
        check({tag, "_noack"}, {31'b0, ack[d]}, 32'd0);
        check({tag, "_idle_data"}, dat_o[d], 32'h0);
      end
      @(posedge clk); #1;
      if (c == int'(ws[d]) + 1) begin
        cyc[d] = 1'b0; stb[d] = 1'b0;
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    ws[0] = 0;
    ws[1] = 3;
    for (int d = 0; d < 2; d++) begin
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      adr[d] = '0; dat_i[d] = '0; sel[d] = '0;
    end
    rst = 1'b0;
    #2;
    check("rst_ack0",  {31'b0, ack[0]}, 32'd0);
    check("rst_data0", dat_o[0], 32'h0);
    check("rst_ack1",  {31'b0, ack[1]}, 32'd0);
    check("rst_data1", dat_o[1], 32'h0);
    #20;
    rst = 1'b1;

    // Zero wait states: full write, byte-select merge, empty select, low addr bits.
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0,        "ws0_wr");
    xfer(0, 1'b0, 32'h10, 32'h0,        4'b1111, 32'hDEADBEEF, "ws0_rd");
    xfer(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 32'h0,        "ws0_wrsel");
    xfer(0, 1'b0, 32'h10, 32'h0,        4'b1111, 32'hDE22BE44, "ws0_rdsel");
    xfer(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'h0,        "ws0_wrnone");
    xfer(0, 1'b0, 32'h13, 32'h0,        4'b1111, 32'hDE22BE44, "ws0_rdlow");

    // Three wait states.
    xfer(1, 1'b1, 32'h40, 32'hCAFEF00D, 4'b1111, 32'h0,        "ws3_wr40");
    xfer(1, 1'b0, 32'h40, 32'h0,        4'b1111, 32'hCAFEF00D, "ws3_rd40");
    xfer(1, 1'b1, 32'h20, 32'h12345678, 4'b1111, 32'h0,        "ws3_wr20");

    // Abort: request high in cycles 0-1, dropped in cycle 2.
    @(posedge clk); #1;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
    adr[1] = 32'h20; dat_i[1] = 32'h0; sel[1] = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      if (c == 2) begin
        cyc[1] = 1'b0; stb[1] = 1'b0;
      end
      @(negedge clk);
      check("abort_noack", {31'b0, ack[1]}, 32'd0);
      @(posedge clk); #1;
    end
    xfer(1, 1'b0, 32'h20, 32'h0, 4'b1111, 32'h12345678, "abort_rd20");

    // Out of range.
    xfer(1, 1'b1, 32'h0,      32'h0BADC0DE, 4'b1111, 32'h0,        "oor_wr0");
    xfer(1, 1'b1, 32'h1000,   32'hAAAAAAAA, 4'b1111, 32'h0,        "oor_wr");
    xfer(1, 1'b0, 32'h1000,   32'h0,        4'b1111, 32'h0,        "oor_rd");
    xfer(1, 1'b0, 32'h0,      32'h0,        4'b1111, 32'h0BADC0DE, "oor_rd0");

    // Reset asserted in cycle 2 of a write.
    @(posedge clk); #1;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
    adr[1] = 32'h20; dat_i[1] = 32'h55555555; sel[1] = 4'b1111;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("midrst_ack",  {31'b0, ack[1]}, 32'd0);
    check("midrst_data", dat_o[1], 32'h0);
    @(posedge clk); @(posedge clk); #1;
    check("midrst_hold_ack", {31'b0, ack[1]}, 32'd0);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    xfer(1, 1'b0, 32'h20, 32'h0, 4'b1111, 32'h12345678, "midrst_rd20");
    xfer(0, 1'b0, 32'h10, 32'h0, 4'b1111, 32'hDE22BE44, "post_rst_ws0");

    check("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wishbone_ram_slave.md
# wishbone_ram_slave

Wishbone slave (responder) that gives bus masters, including the CPU's Wishbone bus interface, word-addressed on-chip RAM. It accepts single classic-cycle reads and writes and honours byte selects. It inserts a parameterised number of wait states and returns a registered, one-cycle acknowledge. It sits behind the bus interconnect as the memory endpoint for instruction or data traffic.

## Interface
Parameters:
- ADDR_WIDTH, 10, word-address bits; RAM depth = 2^ADDR_WIDTH 32-bit words.
- WAIT_STATES, 1, extra cycles before ack; legal range 0..15.

Ports:
- clk  input  1  sole clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- wishbone_addr_i  input  32  byte address from master.
- wishbone_data_i  input  32  write data from master.
- wishbone_we_i  input  1  1 = write, 0 = read.
- wishbone_sel_i  input  4  byte lane enables; bit i covers data[8i+7:8i].
- wishbone_stb_i  input  1  strobe.
- wishbone_cyc_i  input  1  cycle valid.
- wishbone_data_o  output  32  read data; valid only while ack is high.
- wishbone_ack_o  output  1  transfer-complete acknowledge.

## Operation
- Request = wishbone_cyc_i & wishbone_stb_i, sampled at a rising edge.
- FSM states: IDLE, WAIT, ACK.
- IDLE, request sampled:
  - Latch address, write data, we and sel.
  - Load wait counter with WAIT_STATES.
  - If WAIT_STATES = 0, go to ACK; otherwise go to WAIT.
- WAIT:
  - If the request has dropped (cyc or stb low) at an edge, abort: go to IDLE, no write, no ack.
  - Otherwise decrement the counter. When the counter is 1 at an edge, go to ACK.
- Commit happens on the edge entering ACK:
  - Write: bytes with sel=1 are stored; bytes with sel=0 keep their old value.
  - Read: wishbone_data_o is loaded with the addressed word.
- ACK:
  - wishbone_ack_o = 1 for exactly one cycle, then go to IDLE unconditionally.
  - No abort check in ACK; the commit has already happened.
- Address decode:
  - Word index = addr[ADDR_WIDTH+1:2]; addr[1:0] is ignored.
  - Any set bit in addr[31:ADDR_WIDTH+2] marks the access out of range.
  - Out-of-range write: RAM is unchanged. Out-of-range read: returns 0. Ack is still given in both cases, with normal timing.
- Writes always return wishbone_data_o = 0 during ack.
- sel = 0000 on a write: no bytes change, ack is still given.
- RAM contents are not cleared by reset and are undefined until written.

## Timing
- Reset values: wishbone_ack_o = 0, wishbone_data_o = 0, state = IDLE, counter = 0, latched request = 0.
- Reset asserting mid-transfer forces all outputs to their reset values immediately, without waiting for a clock edge. An uncommitted write is dropped.
- Cycle numbering: the request is first high in cycle 0 and is sampled at the edge that ends cycle 0.
- Ack latency: wishbone_ack_o is high in cycle WAIT_STATES+1 and low in every other cycle.
- The master must hold the request and its address, data, we and sel stable through the ack cycle. The slave uses only the values latched in cycle 0.
- wishbone_data_o = 0 whenever wishbone_ack_o = 0.
- Back-to-back requests:
  - The cycle after ACK is always IDLE.
  - A request still asserted in that IDLE cycle is sampled as a new transfer.
  - Minimum request-to-request spacing is WAIT_STATES+2 cycles.
- A request that drops in the same cycle it is first raised is never sampled: no effect.
- Abort and completion on the same edge cannot occur: an abort only exists in WAIT, a completion only in ACK.

## Test plan
- WAIT_STATES=0: write 0xDEADBEEF to addr 0x10 with sel 1111, then read 0x10 → each ack high in cycle 1 only; read returns 0xDEADBEEF.
- Byte select: with 0xDEADBEEF at 0x10, write 0x11223344 with sel 0101, then read 0x10 → 0xDE22BE44.
- WAIT_STATES=3: read from 0x40 → ack low in cycles 1–3, high in cycle 4 only; data_o = 0 outside cycle 4.
- Abort: WAIT_STATES=3, start a write of 0x0 to 0x20 (prior value 0x12345678) and drop cyc/stb in cycle 2 → no ack ever; a later read of 0x20 returns 0x12345678.
- Out of range (ADDR_WIDTH=10): write 0xAAAAAAAA to 0x00001000 → ack given; read of 0x00001000 returns 0; word 0 is unchanged.
- Reset mid-WAIT: WAIT_STATES=3, pull rst low in cycle 2 of a write → ack and data go to 0 immediately; RAM is unchanged; after release, a new read completes normally.
